// File: rtl/demux_pkg.sv
// Shared constants and slot-state encoding for the 1-to-4 stream demultiplexer.
package demux_pkg;
    localparam int NCH           = 4;
    localparam int WIDTH_DEFAULT = 4;
    localparam int SEL_W         = $clog2(NCH);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/stream_demux_1to4_b4_if.sv
// Handshake bundle for the 1-to-4 demux: one input stream, four output channels.
interface stream_demux_1to4_b4_if
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic [SEL_W-1:0] S;
    logic [WIDTH-1:0] I;
    logic             I_valid;
    logic             I_ready;
    logic [WIDTH-1:0] O0;
    logic [WIDTH-1:0] O1;
    logic [WIDTH-1:0] O2;
    logic [WIDTH-1:0] O3;
    logic [NCH-1:0]   O_valid;
    logic [NCH-1:0]   O_ready;

    modport master (
        output S, I, I_valid, O_ready,
        input  I_ready, O0, O1, O2, O3, O_valid
    );

    modport slave (
        input  S, I, I_valid, O_ready,
        output I_ready, O0, O1, O2, O3, O_valid
    );
endinterface

// File: rtl/stream_demux_1to4_b4_slot.sv
// One-entry channel slot: holding register plus EMPTY/FULL state bit.
module stream_demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);
    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load in the same cycle as an unload reloads the slot and keeps it FULL.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = din;
        end else if (unload) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign full = (state_q == SLOT_FULL);
    assign dout = data_q;
endmodule

// File: rtl/stream_demux_1to4_b4.sv
// 1-to-4 stream demux with a one-entry slot per channel.
// Optional STREAM_DEMUX_BYPASS_EN passes I straight to an empty, ready channel.
module stream_demux_1to4_b4
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic                   clk,
    input logic                   rst_n,
    stream_demux_1to4_b4_if.slave bus
);
    logic [NCH-1:0]   sel_oh;
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   load;
    logic [NCH-1:0]   unload;
    logic [NCH-1:0]   bypass;
    logic             i_ready;
    logic             in_xfer;
    logic [WIDTH-1:0] slot_dout [NCH];
    logic [WIDTH-1:0] out_data  [NCH];

    assign sel_oh  = sel_onehot(bus.S);
    assign i_ready = !full[bus.S] || bus.O_ready[bus.S];
    assign in_xfer = bus.I_valid && i_ready;

`ifdef STREAM_DEMUX_BYPASS_EN
    assign bypass = sel_oh & ~full & bus.O_ready & {NCH{bus.I_valid}};
`else
    assign bypass = '0;
`endif

    // A bypassed beat is consumed directly and never occupies the slot.
    assign load   = sel_oh & {NCH{in_xfer}} & ~bypass;
    assign unload = full & bus.O_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load[k]),
            .unload (unload[k]),
            .din    (bus.I),
            .full   (full[k]),
            .dout   (slot_dout[k])
        );
        assign out_data[k] = bypass[k] ? bus.I : slot_dout[k];
    end

    assign bus.I_ready = i_ready;
    assign bus.O_valid = full | bypass;
    assign bus.O0      = out_data[0];
    assign bus.O1      = out_data[1];
    assign bus.O2      = out_data[2];
    assign bus.O3      = out_data[3];
endmodule

// File: tb/tb_stream_demux_1to4_b4.sv
// Self-checking bench for stream_demux_1to4_b4 using per-channel scoreboard queues.
module tb_stream_demux_1to4_b4;
    import demux_pkg::*;

    localparam int WIDTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [WIDTH-1:0] exp_q [NCH][$];

    stream_demux_1to4_b4_if #(.WIDTH(WIDTH)) bus ();

    stream_demux_1to4_b4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [WIDTH-1:0] out_of(input int k);
        case (k)
            0:       return bus.O0;
            1:       return bus.O1;
            2:       return bus.O2;
            default: return bus.O3;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [NCH-1:0] ordy);
        bus.I_valid = v;
        bus.S       = s;
        bus.I       = d;
        bus.O_ready = ordy;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) exp_q[k].delete();
    endtask

    // One clock: check outputs against the scoreboard at negedge, then advance.
    task automatic cycle(input string tag);
        logic [NCH-1:0]   exp_valid;
        logic [NCH-1:0]   byp;
        logic             exp_ready;
        logic [WIDTH-1:0] got;
        int               s;
        @(negedge clk);
        s         = int'(bus.S);
        exp_ready = (exp_q[s].size() == 0) || bus.O_ready[s];
        byp       = '0;
        exp_valid = '0;
        for (int k = 0; k < NCH; k++) begin
            exp_valid[k] = (exp_q[k].size() != 0);
`ifdef STREAM_DEMUX_BYPASS_EN
            byp[k] = (s == k) && bus.I_valid && (exp_q[k].size() == 0) && bus.O_ready[k];
`endif
        end
        exp_valid = exp_valid | byp;
        checks++;
        if (bus.I_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL %s I_ready: got %b expected %b", tag, bus.I_ready, exp_ready);
        end
        checks++;
        if (bus.O_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL %s O_valid: got %b expected %b", tag, bus.O_valid, exp_valid);
        end
        for (int k = 0; k < NCH; k++) begin
            got = out_of(k);
            if (exp_q[k].size() != 0) begin
                checks++;
                if (got !== exp_q[k][0]) begin
                    errors++;
                    $display("[TB] FAIL %s O%0d data: got %h expected %h", tag, k, got, exp_q[k][0]);
                end
                if (bus.O_ready[k]) void'(exp_q[k].pop_front());
            end else if (byp[k]) begin
                checks++;
                if (got !== bus.I) begin
                    errors++;
                    $display("[TB] FAIL %s O%0d bypass: got %h expected %h", tag, k, got, bus.I);
                end
            end
        end
        if (bus.I_valid && exp_ready && !byp[s]) exp_q[s].push_back(bus.I);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 2'd0, '0, '0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.O_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset O_valid: got %b expected 0000", bus.O_valid);
        end
        for (int k = 0; k < NCH; k++) begin
            checks++;
            if (out_of(k) !== '0) begin
                errors++;
                $display("[TB] FAIL reset O%0d: got %h expected 0", k, out_of(k));
            end
        end
        checks++;
        if (bus.I_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset I_ready: got %b expected 1", bus.I_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_model();
    endtask

    task automatic test_stall();
        drive(1'b1, 2'd2, 4'hA, 4'b0000);
        cycle("stall_load");
        drive(1'b0, 2'd2, 4'h0, 4'b0000);
        checks++;
        if (bus.O_valid !== 4'b0100 || bus.O2 !== 4'hA) begin
            errors++;
            $display("[TB] FAIL stall_first O_valid/O2: got %b/%h expected 0100/a", bus.O_valid, bus.O2);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'(i), 4'($urandom_range(0, 15)), 4'b0000);
            cycle("stall_idle");
        end
        checks++;
        if (bus.O2 !== 4'hA) begin
            errors++;
            $display("[TB] FAIL stall_hold O2: got %h expected a", bus.O2);
        end
    endtask

    task automatic test_block();
        drive(1'b1, 2'd2, 4'h7, 4'b0000);
        #1;
        checks++;
        if (bus.I_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL block_s2 I_ready: got %b expected 0", bus.I_ready);
        end
        cycle("block_s2");
        drive(1'b1, 2'd1, 4'h5, 4'b0000);
        #1;
        checks++;
        if (bus.I_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL block_s1 I_ready: got %b expected 1", bus.I_ready);
        end
        cycle("block_s1");
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        checks++;
        if (bus.O_valid !== 4'b0110 || bus.O1 !== 4'h5) begin
            errors++;
            $display("[TB] FAIL block_after O_valid/O1: got %b/%h expected 0110/5", bus.O_valid, bus.O1);
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        cycle("block_drain");
    endtask

    task automatic test_reload();
        drive(1'b1, 2'd3, 4'h3, 4'b0000);
        cycle("reload_fill");
        drive(1'b1, 2'd3, 4'hC, 4'b1000);
        #1;
        checks++;
        if (bus.I_ready !== 1'b1 || bus.O3 !== 4'h3) begin
            errors++;
            $display("[TB] FAIL reload_same I_ready/O3: got %b/%h expected 1/3", bus.I_ready, bus.O3);
        end
        cycle("reload_same");
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        checks++;
        if (bus.O_valid[3] !== 1'b1 || bus.O3 !== 4'hC) begin
            errors++;
            $display("[TB] FAIL reload_after O_valid3/O3: got %b/%h expected 1/c", bus.O_valid[3], bus.O3);
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        cycle("reload_drain");
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 16; b++) begin
            drive(1'b1, 2'(b % 4), 4'(b), 4'b1111);
            cycle("b2b");
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        cycle("b2b_drain");
    endtask

    task automatic test_async_reset();
        drive(1'b1, 2'd0, 4'h6, 4'b0000);
        cycle("ares_fill0");
        drive(1'b1, 2'd1, 4'h9, 4'b0000);
        cycle("ares_fill1");
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        checks++;
        if (bus.O_valid !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL ares_pre O_valid: got %b expected 0011", bus.O_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.O_valid !== 4'b0000 || bus.O0 !== '0 || bus.O1 !== '0 || bus.O2 !== '0 || bus.O3 !== '0) begin
            errors++;
            $display("[TB] FAIL ares_mid O_valid/O0/O1: got %b/%h/%h expected 0000/0/0",
                     bus.O_valid, bus.O0, bus.O1);
        end
        clear_model();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int s = 0; s < NCH; s++) begin
            drive(1'b0, 2'(s), 4'h0, 4'b0000);
            #1;
            checks++;
            if (bus.I_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ares_release S=%0d I_ready: got %b expected 1", s, bus.I_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cycle("random");
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        cycle("random_drain");
    endtask

`ifdef STREAM_DEMUX_BYPASS_EN
    task automatic test_bypass();
        drive(1'b1, 2'd0, 4'h9, 4'b1111);
        #1;
        checks++;
        if (bus.O_valid[0] !== 1'b1 || bus.O0 !== 4'h9) begin
            errors++;
            $display("[TB] FAIL bypass_same O_valid0/O0: got %b/%h expected 1/9", bus.O_valid[0], bus.O0);
        end
        cycle("bypass");
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        checks++;
        if (bus.O_valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL bypass_next O_valid: got %b expected 0000", bus.O_valid);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting stream_demux_1to4_b4 bench");
        test_reset();
`ifdef STREAM_DEMUX_BYPASS_EN
        test_bypass();
`endif
        test_stall();
        test_block();
        test_reload();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
